// File: rtl/nco_fcw_sweep_pkg.sv
// Shared NCO definitions: default operand widths and sweep state encoding.
`timescale 1ns/1ps
package nco_pkg;

    localparam int FCW_W_DEF   = 16;
    localparam int DWELL_W_DEF = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_RETURN = 2'd2;

endpackage

// File: rtl/nco_fcw_sweep_if.sv
// Control/config/status bundle between a sweep controller and its user.
`timescale 1ns/1ps
interface nco_fcw_sweep_if #(
    parameter int FCW_W   = nco_pkg::FCW_W_DEF,
    parameter int DWELL_W = nco_pkg::DWELL_W_DEF
) ();
    logic               start;
    logic               stop;
    logic [FCW_W-1:0]   f_start;
    logic [FCW_W-1:0]   f_stop;
    logic [FCW_W-1:0]   f_step;
    logic [DWELL_W-1:0] dwell;
    logic               loop;
    logic [FCW_W-1:0]   fcw;
    logic               busy;
    logic               step_stb;
    logic               done;

    modport master (
        output start, stop, f_start, f_stop, f_step, dwell, loop,
        input  fcw, busy, step_stb, done
    );

    modport slave (
        input  start, stop, f_start, f_stop, f_step, dwell, loop,
        output fcw, busy, step_stb, done
    );
endinterface

// File: rtl/nco_fcw_sweep_dwell_timer.sv
// Loadable down-counter; expire is high whenever the count has reached zero.
`timescale 1ns/1ps
module nco_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] value,
    output logic         expire
);
    logic [W-1:0] count;

    // clear outranks load so an abort landing with a restart leaves the timer idle
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (load)
            count <= value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign expire = (count == '0);
endmodule

// File: rtl/nco_fcw_sweep.sv
// Frequency control word sweep generator feeding the NCO phase accumulator.
// Define SWEEP_BIDIR_EN for triangle (up/down) sweeps; default is sawtooth only.
`timescale 1ns/1ps
module nco_fcw_sweep
    import nco_pkg::*;
#(
    parameter int FCW_W   = FCW_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    nco_fcw_sweep_if.slave bus
);
`ifdef SWEEP_BIDIR_EN
    localparam bit BIDIR = 1'b1;
`else
    localparam bit BIDIR = 1'b0;
`endif

    logic [1:0]         state, state_n;
    logic [FCW_W-1:0]   fcw_q, fcw_n;
    logic               stb_q, stb_n;
    logic               done_q, done_n;
    logic [FCW_W-1:0]   s_start, s_stop, s_step;
    logic [DWELL_W-1:0] s_dwell;
    logic               s_loop, dir_up;
    logic               expire, tmr_load;
    logic [DWELL_W-1:0] tmr_value;
    logic [FCW_W-1:0]   fwd_next, back_next;

    // One step toward target, computed one bit wider so a carry or borrow clamps instead of wrapping
    function automatic logic [FCW_W-1:0] step_toward(
        input logic [FCW_W-1:0] cur,
        input logic [FCW_W-1:0] step,
        input logic [FCW_W-1:0] target,
        input logic             up
    );
        logic [FCW_W:0] sum;
        if (up) begin
            sum = {1'b0, cur} + {1'b0, step};
            return (sum > {1'b0, target}) ? target : sum[FCW_W-1:0];
        end
        sum = {1'b0, cur} - {1'b0, step};
        return (sum[FCW_W] || (sum[FCW_W-1:0] < target)) ? target : sum[FCW_W-1:0];
    endfunction

    assign fwd_next  = step_toward(fcw_q, s_step, s_stop, dir_up);
    assign back_next = step_toward(fcw_q, s_step, s_start, !dir_up);
    assign tmr_value = bus.start ? bus.dwell : s_dwell;

    nco_dwell_timer #(.W(DWELL_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .clear  (bus.stop),
        .value  (tmr_value),
        .expire (expire)
    );

    // Next-state logic: stop outranks start, start outranks dwell expiry
    always_comb begin
        state_n  = state;
        fcw_n    = fcw_q;
        stb_n    = 1'b0;
        done_n   = 1'b0;
        tmr_load = 1'b0;
        if (bus.stop) begin
            state_n = ST_IDLE;
        end else if (bus.start) begin
            state_n  = ST_RUN;
            fcw_n    = bus.f_start;
            stb_n    = 1'b1;
            tmr_load = 1'b1;
        end else if (state != ST_IDLE && expire) begin
            case (state)
                ST_RUN: begin
                    if (fcw_q != s_stop) begin
                        fcw_n    = fwd_next;
                        stb_n    = (s_step != '0);
                        tmr_load = 1'b1;
                    end else if (BIDIR && fcw_q != s_start) begin
                        state_n  = ST_RETURN;
                        fcw_n    = back_next;
                        stb_n    = 1'b1;
                        tmr_load = 1'b1;
                    end else if (s_loop) begin
                        fcw_n    = s_start;
                        stb_n    = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end
                end
`ifdef SWEEP_BIDIR_EN
                ST_RETURN: begin
                    if (fcw_q != s_start) begin
                        fcw_n    = back_next;
                        stb_n    = 1'b1;
                        tmr_load = 1'b1;
                    end else if (s_loop) begin
                        state_n  = ST_RUN;
                        fcw_n    = fwd_next;
                        stb_n    = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end
                end
`endif
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State, outputs and shadow config; config is only captured by a start that is not aborted
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            fcw_q   <= '0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
            s_start <= '0;
            s_stop  <= '0;
            s_step  <= '0;
            s_dwell <= '0;
            s_loop  <= 1'b0;
            dir_up  <= 1'b1;
        end else begin
            state  <= state_n;
            fcw_q  <= fcw_n;
            stb_q  <= stb_n;
            done_q <= done_n;
            if (bus.start && !bus.stop) begin
                s_start <= bus.f_start;
                s_stop  <= bus.f_stop;
                s_step  <= bus.f_step;
                s_dwell <= bus.dwell;
                s_loop  <= bus.loop;
                dir_up  <= (bus.f_stop >= bus.f_start);
            end
        end
    end

    assign bus.fcw      = fcw_q;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.step_stb = stb_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_nco_fcw_sweep.sv
// Directed scoreboard bench for nco_fcw_sweep; covers the RETURN path when SWEEP_BIDIR_EN is defined.
`timescale 1ns/1ps
module tb_nco_fcw_sweep;

    typedef struct {
        logic [15:0] fcw;
        logic        busy;
        logic        stb;
        logic        done;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    exp_t  sbq[$];
    int    seq[$];
    int    vectors = 0;
    int    miscompares = 0;
    string curTag = "none";

    always #5 clk = ~clk;

    nco_fcw_sweep_if bus ();

    nco_fcw_sweep dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference value sequence of one sweep pass, clamped in plain integer arithmetic
    function automatic void buildSeq(input int fs, input int fe, input int st, input bit bidir);
        int v;
        seq.delete();
        v = fs;
        seq.push_back(v);
        while (v != fe) begin
            if (fe >= fs) v = (v + st > fe) ? fe : v + st;
            else          v = (v - st < fe) ? fe : v - st;
            seq.push_back(v);
        end
        if (bidir && fs != fe) begin
            while (v != fs) begin
                if (fe >= fs) v = (v - st < fs) ? fs : v - st;
                else          v = (v + st > fs) ? fs : v + st;
                seq.push_back(v);
            end
        end
    endfunction

    function automatic void pushRec(input int v, input bit b, input bit s, input bit d);
        exp_t e;
        e.fcw  = v[15:0];
        e.busy = b;
        e.stb  = s;
        e.done = d;
        sbq.push_back(e);
    endfunction

    function automatic void pushSweep(input int dwell, input int reps, input bit finish, input int tail);
        int last;
        last = seq[seq.size()-1];
        for (int r = 0; r < reps; r++)
            foreach (seq[i])
                for (int c = 0; c <= dwell; c++)
                    pushRec(seq[i], 1'b1, c == 0, 1'b0);
        if (finish) begin
            pushRec(last, 1'b0, 1'b0, 1'b1);
            for (int t = 0; t < tail; t++)
                pushRec(last, 1'b0, 1'b0, 1'b0);
        end
    endfunction

    task automatic applyStimulus(input logic [15:0] fs, input logic [15:0] fe,
                                 input logic [15:0] st, input logic [15:0] dw, input logic lp);
        bus.f_start = fs;
        bus.f_stop  = fe;
        bus.f_step  = st;
        bus.dwell   = dw;
        bus.loop    = lp;
        bus.start   = 1'b1;
    endtask

    task automatic checkOutput();
        exp_t e;
        e = sbq.pop_front();
        vectors++;
        assert ({bus.fcw, bus.busy, bus.step_stb, bus.done} === {e.fcw, e.busy, e.stb, e.done})
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed fcw=%h busy=%b stb=%b done=%b, expected fcw=%h busy=%b stb=%b done=%b",
                   curTag, bus.fcw, bus.busy, bus.step_stb, bus.done, e.fcw, e.busy, e.stb, e.done);
        end
    endtask

    // Check n queued cycles (all if n<0); config inputs are scrambled so shadowing is exercised
    task automatic drain(input int n);
        int k;
        k = (n < 0 || n > sbq.size()) ? sbq.size() : n;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.stop    = 1'b0;
            bus.f_start = 16'hDEAD;
            bus.f_stop  = 16'h0001;
            bus.f_step  = 16'h0003;
            bus.dwell   = 16'h0007;
            bus.loop    = ~bus.loop;
            checkOutput();
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.f_start = '0;
        bus.f_stop  = '0;
        bus.f_step  = '0;
        bus.dwell   = '0;
        bus.loop    = 1'b0;
        rst         = 1'b1;

        curTag = "reset";
        pushRec(0, 0, 0, 0);
        pushRec(0, 0, 0, 0);
        drain(-1);
        rst = 1'b0;

        curTag = "up_dwell3";
        applyStimulus(16'd10, 16'd30, 16'd5, 16'd3, 1'b0);
        buildSeq(10, 30, 5, 1'b0);
        pushSweep(3, 1, 1'b1, 2);
        drain(-1);

        curTag = "up_clamp";
        applyStimulus(16'd10, 16'd30, 16'd7, 16'd0, 1'b0);
        buildSeq(10, 30, 7, 1'b0);
        pushSweep(0, 1, 1'b1, 1);
        drain(-1);

        curTag = "down";
        applyStimulus(16'd30, 16'd10, 16'd10, 16'd1, 1'b0);
        buildSeq(30, 10, 10, 1'b0);
        pushSweep(1, 1, 1'b1, 1);
        drain(-1);

        curTag = "no_wrap";
        applyStimulus(16'hFFF0, 16'hFFFF, 16'h0020, 16'd2, 1'b0);
        buildSeq(32'hFFF0, 32'hFFFF, 32'h0020, 1'b0);
        pushSweep(2, 1, 1'b1, 1);
        drain(-1);

        curTag = "loop";
        applyStimulus(16'd10, 16'd20, 16'd10, 16'd2, 1'b1);
        buildSeq(10, 20, 10, 1'b0);
        pushSweep(2, 2, 1'b0, 0);
        pushRec(10, 1, 1, 0);
        pushRec(10, 1, 0, 0);
        drain(-1);
        curTag = "stop_mid_dwell";
        bus.stop = 1'b1;
        pushRec(10, 0, 0, 0);
        pushRec(10, 0, 0, 0);
        pushRec(10, 0, 0, 0);
        drain(-1);

        curTag = "stop_beats_start";
        applyStimulus(16'd99, 16'd200, 16'd1, 16'd0, 1'b0);
        bus.stop = 1'b1;
        pushRec(10, 0, 0, 0);
        pushRec(10, 0, 0, 0);
        drain(-1);

        curTag = "zero_step";
        applyStimulus(16'd40, 16'd50, 16'd0, 16'd0, 1'b0);
        pushRec(40, 1, 1, 0);
        for (int i = 0; i < 5; i++) pushRec(40, 1, 0, 0);
        drain(-1);
        bus.stop = 1'b1;
        pushRec(40, 0, 0, 0);
        drain(-1);

        curTag = "restart_busy";
        applyStimulus(16'd10, 16'd30, 16'd5, 16'd3, 1'b0);
        buildSeq(10, 30, 5, 1'b0);
        pushSweep(3, 1, 1'b1, 0);
        drain(5);
        sbq.delete();
        applyStimulus(16'd100, 16'd90, 16'd5, 16'd0, 1'b0);
        buildSeq(100, 90, 5, 1'b0);
        pushSweep(0, 1, 1'b1, 1);
        drain(-1);

        curTag = "rst_mid_sweep";
        applyStimulus(16'd10, 16'd30, 16'd5, 16'd3, 1'b1);
        buildSeq(10, 30, 5, 1'b0);
        pushSweep(3, 1, 1'b0, 0);
        drain(7);
        sbq.delete();
        rst = 1'b1;
        pushRec(0, 0, 0, 0);
        pushRec(0, 0, 0, 0);
        drain(-1);
        rst = 1'b0;
        pushRec(0, 0, 0, 0);
        drain(-1);

`ifdef SWEEP_BIDIR_EN
        curTag = "bidir";
        applyStimulus(16'd10, 16'd30, 16'd10, 16'd0, 1'b0);
        buildSeq(10, 30, 10, 1'b1);
        pushSweep(0, 1, 1'b1, 2);
        drain(-1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
